// File: rtl/button_pkg.sv
// Shared constants and types for the button event arbiter.
//   NUM_BUTTONS_DEFAULT : default number of press inputs
//   COOLDOWN_DEFAULT    : default per-button lockout after an accepted event (~50 ms @ 48 MHz)
//   arb_state_t         : arbiter FSM state
package button_pkg;
    localparam int          NUM_BUTTONS_DEFAULT = 4;
    localparam logic [23:0] COOLDOWN_DEFAULT    = 24'd2400000;

    typedef enum logic {IDLE, PRESENT} arb_state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: returns the first set bit of req, searching upward from
// last+1 and wrapping modulo N.
//   req     in  N      request vector
//   last    in  IDX_W  index granted most recently
//   grant   out IDX_W  winning index (0 when no request)
//   any_req out 1      req is non-zero
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant,
    output logic             any_req
);
    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // k runs 1..N so the last winner is checked last, not first.
        for (int k = 1; k <= N; k++) begin
            idx = IDX_W'((int'(last) + k) % N);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/button_event_arbiter.sv
// Latches one-cycle press pulses from the debouncer bank, arbitrates them
// round-robin and presents one event at a time over valid/ready. Each accepted
// event locks its button out for COOLDOWN cycles; presses that collide with an
// already pending or currently presented press of the same button are lost and
// raise the sticky dropped flag.
//   clk, reset     clock, synchronous active-high reset
//   press_in       one-cycle press pulses, bit i = button i
//   event_valid    event presented
//   event_id       index of presented button
//   event_ready    consumer accepts event
//   pending        latched, not-yet-granted presses
//   dropped        sticky lost-press flag
//   clear_dropped  clears dropped (a same-cycle drop wins)
module button_event_arbiter
    import button_pkg::*;
#(
    parameter int          NUM_BUTTONS = NUM_BUTTONS_DEFAULT,
    parameter logic [23:0] COOLDOWN    = COOLDOWN_DEFAULT,
    localparam int         IDX_W       = $clog2(NUM_BUTTONS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] press_in,
    output logic                   event_valid,
    output logic [IDX_W-1:0]       event_id,
    input  logic                   event_ready,
    output logic [NUM_BUTTONS-1:0] pending,
    output logic                   dropped,
    input  logic                   clear_dropped
);
    arb_state_t             state, state_nxt;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       win_id;
    logic                   any_req;
    logic                   handshake;
    logic [NUM_BUTTONS-1:0] accept_set;
    logic [NUM_BUTTONS-1:0] drop_hit;
    logic [NUM_BUTTONS-1:0] grant_clr;

    rr_priority_picker #(
        .N     (NUM_BUTTONS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (pending),
        .last    (last_grant),
        .grant   (win_id),
        .any_req (any_req)
    );

    // event_valid is only ever high in PRESENT, so this is the accept edge.
    assign handshake = event_valid & event_ready;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        logic [23:0] cd_cnt;
        logic        cd_zero;
        logic        busy;

        assign cd_zero = (cd_cnt == 24'd0);
        // Uses pre-edge pending, so a press for this cycle's grant winner is a drop.
        assign busy    = pending[i] | (state == PRESENT && event_id == IDX_W'(i));

        assign accept_set[i] = press_in[i] & cd_zero & ~busy;
        assign drop_hit[i]   = press_in[i] & cd_zero &  busy;

        always_ff @(posedge clk) begin
            if (reset)
                cd_cnt <= 24'd0;
            else if (handshake && event_id == IDX_W'(i))
                cd_cnt <= COOLDOWN;
            else if (!cd_zero)
                cd_cnt <= cd_cnt - 24'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_clr = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt         = PRESENT;
                    grant_clr[win_id] = 1'b1;
                end
            end
            PRESENT: begin
                if (event_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            event_valid <= 1'b0;
            event_id    <= '0;
            last_grant  <= IDX_W'(NUM_BUTTONS - 1);
            pending     <= '0;
            dropped     <= 1'b0;
        end else begin
            state   <= state_nxt;
            // accept_set never hits the winner (its pending bit blocks it), so no overlap.
            pending <= (pending & ~grant_clr) | accept_set;

            if (state == IDLE && any_req) begin
                event_valid <= 1'b1;
                event_id    <= win_id;
            end else if (handshake) begin
                event_valid <= 1'b0;
                last_grant  <= event_id;
            end

            if (|drop_hit)          dropped <= 1'b1;
            else if (clear_dropped) dropped <= 1'b0;
        end
    end
endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Collects single-cycle press pulses from NUM_BUTTONS debouncer instances and arbitrates them round-robin.
- Presents one event at a time to the game FSM over a valid/ready handshake.
- Enforces a per-button cooldown after each accepted event and flags presses that were lost.
- Sits between the bank of button debouncers and the game-control logic.

Parameters:
- NUM_BUTTONS, 4, number of press inputs; must be at least 2.
- COOLDOWN, 24'd2400000, cycles a button is ignored after its event is accepted (~50 ms at 48 MHz).
- IDX_W, $clog2(NUM_BUTTONS), localparam, width of event_id.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous and active-high.
- press_in  in  NUM_BUTTONS  one-cycle press pulses from the debouncers; bit i is button i.
- event_valid  out  1  an event is being presented.
- event_id  out  IDX_W  index of the presented button.
- event_ready  in  1  consumer accepts the event.
- pending  out  NUM_BUTTONS  latched, not-yet-granted presses.
- dropped  out  1  sticky flag: a press was lost.
- clear_dropped  in  1  clears dropped.

Behaviour:
- Reset:
  - Synchronous, active-high, applied on the clk edge.
  - Clears event_valid, event_id, pending, dropped and all cooldown counters.
  - Sets state to IDLE and last_grant to NUM_BUTTONS-1, so button 0 has first priority.
  - Reset during PRESENT withdraws the event; no handshake is counted and no cooldown starts.
- Press capture, per button i, each cycle:
  - press_in[i]=1 and cooldown[i]!=0: ignored silently.
  - press_in[i]=1, cooldown[i]=0, and either pending[i]=1 or (state PRESENT and event_id=i): ignored and dropped<=1.
  - Otherwise: pending[i]<=1 on the next edge.
- FSM states: IDLE and PRESENT.
  - IDLE with pending!=0:
    - Winner is the first set bit searched from last_grant+1 upward, wrapping modulo NUM_BUTTONS.
    - Next edge: event_valid<=1, event_id<=winner, pending[winner]<=0, state<=PRESENT.
  - IDLE with pending=0: stay in IDLE; event_valid=0.
  - PRESENT:
    - event_valid and event_id are held stable until event_valid & event_ready.
    - On the handshake edge: event_valid<=0, cooldown[event_id]<=COOLDOWN, last_grant<=event_id, state<=IDLE.
  - event_ready while event_valid=0 has no effect.
- Latency and throughput:
  - press_in[i] at cycle t gives pending[i]=1 at t+1 and event_valid=1 at t+2 (IDLE, no other pending).
  - event_valid is low for at least one cycle between consecutive events, so the best case is one event every 2 cycles with ready tied high.
- Cooldown:
  - Each per-button counter is 24 bits and decrements by 1 per cycle while non-zero, saturating at 0.
  - The button becomes eligible in the cycle its counter reads 0.
  - Cooldown does not block arbitration of a pending bit that was set before the counter was loaded.
- dropped:
  - Set by any drop condition; cleared by clear_dropped.
  - If a clear and a drop happen in the same cycle, set wins.
- Simultaneous presses on several buttons in one cycle: all are latched into pending and granted in round-robin order.
- The press-capture checks use the pre-edge pending value. A press for the winner in the grant cycle is therefore a drop.

Decomposition:
- Package button_pkg:
  - NUM_BUTTONS_DEFAULT and COOLDOWN_DEFAULT constants.
  - typedef enum logic {IDLE, PRESENT} arb_state_t.
- One combinational sub-module, rr_priority_picker:
  - Inputs: req vector and last index.
  - Outputs: grant index and any_req.
- Cooldown counters, pending register and FSM stay in the top module.

Test Plan (COOLDOWN=8, NUM_BUTTONS=4 for simulation):
1. Reset, then a press_in=4'b0010 pulse at cycle t with ready=1 -> pending[1]=1 at t+1, event_valid=1 with event_id=1 at t+2, event_valid=0 at t+3.
2. press_in=4'b1111 in one cycle after reset, ready=1 -> events in order 0,1,2,3, each valid for one cycle separated by one idle cycle; pending returns to 0; dropped=0.
3. Press button 2, hold ready=0 for 10 cycles, then raise it -> event_id=2 stays stable and valid for all 10 cycles; a second press of button 2 in that window sets dropped=1.
4. Button 3 accepted at cycle t, press again at t+4 -> ignored, no pending, dropped unchanged; press at t+10 -> pending[3]=1 and a new event follows.
5. Assert reset during PRESENT with event_id=1 -> next cycle event_valid=0, pending=0, dropped=0; the next press of button 0 is granted first.
6. Set dropped, then assert clear_dropped in the same cycle as a new drop -> dropped stays 1; clear_dropped alone -> dropped=0 next cycle.
